// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_ACK_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0] hi_req_s;
    logic [N_REQ-1:0] pool_s;
    logic             found_s;

    // Prefer requests at or above ptr; otherwise wrap to the lowest index.
    always_comb begin
        hi_req_s = '0;
        onehot_o = '0;
        idx_o    = '0;
        found_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(ptr_i)) begin
                hi_req_s[i] = req_i[i];
            end else begin
                hi_req_s[i] = 1'b0;
            end
        end
        pool_s = (|hi_req_s) ? hi_req_s : req_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && pool_s[i]) begin
                found_s     = 1'b1;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Optional packet lock is built when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]       tx_din,
    output logic                    tx_din_rdy,
    input  logic                    tx_rdy,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] tx_din_q, tx_din_d;
    logic              din_rdy_q, din_rdy_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [N_REQ-1:0]  pick_req_s, pick_oh_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s, start_ok_s, timeout_s;
    logic [BYTE_W-1:0] pick_byte_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // While locked only the owner may compete, and only once it has a byte.
    assign pick_req_s = lock_q ? (req_valid & grant_q) : req_valid;
    assign start_ok_s = lock_q ? |(req_valid & grant_q) : |req_valid;
`else
    logic unused_last_s;

    assign unused_last_s = ^req_last;
    assign pick_req_s    = req_valid;
    assign start_ok_s    = |req_valid;
`endif

    assign pick_byte_s = req_data[BYTE_W*int'(pick_idx_s) +: BYTE_W];
    assign timeout_s   = (state_q == ST_WAIT_ACK) && tx_rdy &&
                         (cnt_q >= CNT_W'(ACK_TIMEOUT - 1));

    uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (pick_req_s),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            tx_din_q    <= '0;
            din_rdy_q   <= 1'b0;
            req_ready_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            tx_din_q    <= tx_din_d;
            din_rdy_q   <= din_rdy_d;
            req_ready_q <= req_ready_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q      <= lock_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_rdy && start_ok_s) state_d = ST_ARB;
                else                      state_d = ST_IDLE;
            end
            ST_ARB: begin
                if (pick_any_s) state_d = ST_LOAD;
                else            state_d = ST_IDLE;
            end
            ST_LOAD:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!tx_rdy)        state_d = ST_WAIT_DONE;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (tx_rdy) state_d = ST_IDLE;
                else        state_d = ST_WAIT_DONE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; strobe/busy follow the next state.
    always_comb begin
        tx_din_d    = tx_din_q;
        req_ready_d = '0;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d      = lock_q;
        last_d      = last_q;
        idx_d       = idx_q;
`endif
        case (state_q)
            ST_ARB: begin
                if (pick_any_s) begin
                    tx_din_d    = pick_byte_s;
                    req_ready_d = pick_oh_s;
                    grant_d     = pick_oh_s;
                    cnt_d       = '0;
`ifdef UART_TX_ARB_LOCK_EN
                    idx_d       = pick_idx_s;
                    last_d      = req_last[pick_idx_s];
`else
                    ptr_d       = IDX_W'(wrap_inc(32'(pick_idx_s), 32'(N_REQ)));
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT_ACK: begin
                if (!tx_rdy) begin
                    cnt_d = cnt_q;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    grant_d = '0;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d  = 1'b0;
                    ptr_d   = IDX_W'(wrap_inc(32'(idx_q), 32'(N_REQ)));
`endif
                end else begin
                    cnt_d = (cnt_q == CNT_W'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_rdy) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (last_q) begin
                        grant_d = '0;
                        lock_d  = 1'b0;
                        ptr_d   = IDX_W'(wrap_inc(32'(idx_q), 32'(N_REQ)));
                    end else begin
                        lock_d  = 1'b1;
                    end
`else
                    grant_d = '0;
`endif
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        din_rdy_d = (state_d == ST_WAIT_ACK);
        busy_d    = (state_d != ST_IDLE);
    end

    assign tx_din      = tx_din_q;
    assign tx_din_rdy  = din_rdy_q;
    assign req_ready   = req_ready_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a small tx responder model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_din;
    logic        tx_din_rdy;
    logic        tx_rdy;
    logic [3:0]  grant;
    logic        busy;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // tx responder model state
    int   ack_dly   = 2;
    int   frame_len = 3;
    int   ack_cnt   = 0;
    int   frame_cnt = 0;
    bit   stuck     = 1'b0;
    logic prev_rdy  = 1'b0;
    int   low_run   = 100;
    int   loads     = 0;
    logic [7:0] rise_byte [0:15];

    logic [3:0] pulse_log [0:7];
    logic [7:0] byte_log  [0:7];
    int         n_pulse;

    logic [3:0] s2_oh   [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] s2_byte [0:4] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
`ifdef UART_TX_ARB_LOCK_EN
    logic [3:0] s5_oh   [0:3] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
    logic [7:0] s5_byte [0:3] = '{8'hC0, 8'hC1, 8'hC2, 8'hB1};
`else
    logic [3:0] s5_oh   [0:3] = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
    logic [7:0] s5_byte [0:3] = '{8'hC0, 8'hB1, 8'hC1, 8'hB1};
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .ACK_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_din      (tx_din),
        .tx_din_rdy  (tx_din_rdy),
        .tx_rdy      (tx_rdy),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, then run the tx responder.
    task automatic step();
        @(posedge clk);
        #1;
        if (tx_din_rdy && !prev_rdy) begin
            check("load_gap", 32'(low_run >= 2), 32'd1);
            if (loads < 16) rise_byte[loads] = tx_din;
            loads++;
            if (!stuck) ack_cnt = ack_dly;
        end
        if (tx_din_rdy) low_run = 0;
        else            low_run++;
        prev_rdy = tx_din_rdy;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                tx_rdy    = 1'b0;
                frame_cnt = frame_len;
            end
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) tx_rdy = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((busy !== 1'b0 || tx_rdy !== 1'b1) && g < 200) begin
            step();
            g++;
        end
        check(tag, 32'(g < 200), 32'd1);
    endtask

    task automatic wait_pulse(input string tag);
        int g = 0;
        while (req_ready == 4'b0000 && g < 200) begin
            step();
            g++;
        end
        check(tag, 32'(g < 200), 32'd1);
    endtask

    initial begin
        int guard;
        int n_high;
        int k2;

        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        req_last  = 4'b0000;
        tx_rdy    = 1'b1;
        step();
        step();
        check("rst_tx_din",     32'(tx_din),      32'h00);
        check("rst_din_rdy",    32'(tx_din_rdy),  32'd0);
        check("rst_req_ready",  32'(req_ready),   32'd0);
        check("rst_grant",      32'(grant),       32'd0);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_err",        32'(err_timeout), 32'd0);
        rst = 1'b0;
        step();

        // Single requester, ack after 2 cycles, 3-cycle frame.
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("s1_din_rdy",   32'(tx_din_rdy), 32'(c == 3 || c == 4));
            check("s1_req_ready", 32'(req_ready),  (c == 2) ? 32'd1 : 32'd0);
            check("s1_busy",      32'(busy),       32'(c <= 7));
            check("s1_grant",     32'(grant),      (c >= 2 && c <= 7) ? 32'd1 : 32'd0);
            if (c >= 2) check("s1_tx_din", 32'(tx_din), 32'hA5);
            if (c == 2) req_valid = 4'b0000;
        end
        check("s1_loads", 32'(loads), 32'd1);

        // All four valid continuously: rotation 0,1,2,3,0.
        do_reset();
        req_data  = 32'h4332_2110;
        req_valid = 4'b1111;
        loads     = 0;
        n_pulse   = 0;
        guard     = 0;
        while (n_pulse < 5 && guard < 300) begin
            step();
            guard++;
            if (req_ready != 4'b0000) begin
                pulse_log[n_pulse] = req_ready;
                byte_log[n_pulse]  = tx_din;
                n_pulse++;
                if (n_pulse == 5) req_valid = 4'b0000;
            end
        end
        check("s2_pulse_count", 32'(n_pulse), 32'd5);
        wait_idle("s2_idle");
        check("s2_loads", 32'(loads), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("s2_grant_order", 32'(pulse_log[i]), 32'(s2_oh[i]));
            check("s2_byte",        32'(byte_log[i]),  32'(s2_byte[i]));
            check("s2_loaded_byte", 32'(rise_byte[i]), 32'(s2_byte[i]));
        end

        // Stuck transmitter: timeout after 64 cycles of strobe, then next requester.
        stuck     = 1'b1;
        req_valid = 4'b0011;
        wait_pulse("s3_wait_first");
        check("s3_first_owner", 32'(req_ready), 32'b0010);
        check("s3_first_byte",  32'(tx_din),    32'h21);
        guard = 0;
        while (!tx_din_rdy && guard < 20) begin
            step();
            guard++;
        end
        n_high = 0;
        while (tx_din_rdy && guard < 300) begin
            n_high++;
            step();
            guard++;
        end
        check("s3_strobe_cycles", 32'(n_high),      32'd64);
        check("s3_err_pulse",     32'(err_timeout), 32'd1);
        check("s3_grant_clear",   32'(grant),       32'd0);
        check("s3_idle",          32'(busy),        32'd0);
        req_valid = 4'b0001;
        stuck     = 1'b0;
        step();
        check("s3_err_one_cycle", 32'(err_timeout), 32'd0);
        wait_pulse("s3_wait_next");
        check("s3_next_owner", 32'(req_ready), 32'b0001);
        check("s3_next_byte",  32'(tx_din),    32'h10);
        req_valid = 4'b0000;
        wait_idle("s3_idle_wait");

        // Reset while the frame is in flight (WAIT_DONE).
        req_valid = 4'b0100;
        guard = 0;
        while (!tx_din_rdy && guard < 50) begin
            step();
            guard++;
        end
        while (tx_din_rdy && guard < 100) begin
            step();
            guard++;
        end
        check("s4_reach_done", 32'(guard < 100), 32'd1);
        check("s4_grant_done", 32'(grant),       32'b0100);
        check("s4_busy_done",  32'(busy),        32'd1);
        rst       = 1'b1;
        req_valid = 4'b1001;
        step();
        check("s4_rst_tx_din",  32'(tx_din),      32'h00);
        check("s4_rst_din_rdy", 32'(tx_din_rdy),  32'd0);
        check("s4_rst_grant",   32'(grant),       32'd0);
        check("s4_rst_busy",    32'(busy),        32'd0);
        check("s4_rst_err",     32'(err_timeout), 32'd0);
        step();
        check("s4_rst_ready",   32'(req_ready),   32'd0);
        rst = 1'b0;
        wait_pulse("s4_wait_post");
        check("s4_post_owner", 32'(req_ready), 32'b0001);
        check("s4_post_byte",  32'(tx_din),    32'h10);
        req_valid = 4'b0000;
        wait_idle("s4_idle_wait");

        // Requester 2 sends a 3-byte packet while requester 1 is waiting.
        do_reset();
        req_data[23:16] = 8'hC0;
        req_data[15:8]  = 8'hB1;
        req_last        = 4'b0000;
        req_valid       = 4'b0100;
        n_pulse = 0;
        k2      = 0;
        guard   = 0;
        while (n_pulse < 4 && guard < 400) begin
            step();
            guard++;
            if (req_ready != 4'b0000) begin
                pulse_log[n_pulse] = req_ready;
                byte_log[n_pulse]  = tx_din;
                n_pulse++;
                if (req_ready[2]) begin
                    k2++;
                    req_valid[1] = 1'b1;
                    if (k2 == 1) begin
                        req_data[23:16] = 8'hC1;
                        req_last[2]     = 1'b0;
                    end else if (k2 == 2) begin
                        req_data[23:16] = 8'hC2;
                        req_last[2]     = 1'b1;
                    end else begin
                        req_valid[2] = 1'b0;
                    end
                end
                if (n_pulse == 4) req_valid = 4'b0000;
            end
        end
        check("s5_pulse_count", 32'(n_pulse), 32'd4);
        wait_idle("s5_idle");
        for (int i = 0; i < 4; i++) begin
            check("s5_owner", 32'(pulse_log[i]), 32'(s5_oh[i]));
            check("s5_byte",  32'(byte_log[i]),  32'(s5_byte[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter (`tx` block) between `N_REQ` byte-stream requesters. Round-robin arbitration picks one pending byte. The block drives the transmitter's `din`/`din_rdy` load handshake and waits on `tx_rdy` until the frame completes. It sits between the command/response sources and the `tx` instance inside the UART controller, and it owns the only write path into that transmitter.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ACK_TIMEOUT`, default 64: maximum clk cycles to wait for `tx_rdy` to fall after `tx_din_rdy` rises.

- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: requester i has a byte pending.
- `req_data`  in  8*N_REQ: byte of requester i, at bits [8i+7:8i].
- `req_last`  in  N_REQ: byte i ends a packet (used only with the lock feature).
- `req_ready`  out  N_REQ: one-cycle pulse when requester i's byte is captured.
- `tx_din`  out  8: byte to transmitter.
- `tx_din_rdy`  out  1: load strobe to transmitter; the transmitter is rising-edge sensitive.
- `tx_rdy`  in  1: transmitter idle/ready.
- `grant`  out  N_REQ: one-hot current owner; all zeros when no owner.
- `busy`  out  1: high in any state except IDLE.
- `err_timeout`  out  1: one-cycle pulse on ACK timeout.

## Operation
- FSM states: IDLE, ARB, LOAD, WAIT_ACK, WAIT_DONE.
- **IDLE**
  - `tx_din_rdy`=0.
  - If `tx_rdy`=1 and any `req_valid`, go to ARB.
- **ARB** (1 cycle)
  - Round-robin pick: search starts at `ptr` and wraps modulo N_REQ.
  - Capture `req_data[winner]` into `tx_din`, pulse `req_ready[winner]`, set `grant`.
  - `ptr` becomes (winner+1) mod N_REQ.
  - Go to LOAD.
- **LOAD** (1 cycle): assert `tx_din_rdy`=1, then go to WAIT_ACK.
- **WAIT_ACK**
  - Hold `tx_din_rdy`=1 and `tx_din` stable.
  - On `tx_rdy`=0: drop `tx_din_rdy` and go to WAIT_DONE.
  - After ACK_TIMEOUT cycles without `tx_rdy`=0: drop `tx_din_rdy`, pulse `err_timeout`, discard the byte, clear `grant`, go to IDLE.
- **WAIT_DONE**
  - Keep `tx_din` stable.
  - On `tx_rdy`=1: clear `grant` (unless locked) and go to IDLE.
- `tx_din_rdy` is low for at least 2 cycles (IDLE + ARB) between loads. This guarantees a clean rising edge for every byte.
- Simultaneous requests: exactly one winner per ARB. No requester waits more than N_REQ−1 grants.
- `req_valid` dropping after ARB has no effect; the byte is already captured.
- Timeout counter: width clog2(ACK_TIMEOUT+1), saturating, cleared on LOAD entry.

## Timing
- Reset values:
  - FSM=IDLE, `ptr`=0
  - `tx_din`=8'h00, `tx_din_rdy`=0
  - `req_ready`=0, `grant`=0, `busy`=0, `err_timeout`=0
- Reset mid-frame: all outputs return to reset values on the next edge. The in-flight byte is lost and no `req_ready` is reissued.
- Latency from `req_valid` in IDLE (with `tx_rdy`=1) to `tx_din_rdy`=1: 3 cycles (IDLE→ARB→LOAD, registered output).
- `req_ready` is high exactly in the cycle after ARB, coincident with `grant` becoming valid.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- **Defined:** packet lock.
  - A byte captured with `req_last`=0 keeps `grant` after WAIT_DONE.
  - The next ARB considers only the owner and waits in IDLE until that owner's `req_valid` is high.
  - The lock releases after a byte with `req_last`=1 or on timeout.
  - `ptr` advances only on release.
- **Undefined:** `req_last` is ignored, and arbitration rotates after every byte.

## Structure
- Package `uart_arb_pkg`: state enum, `BYTE_W`=8, and a default-timeout constant.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs: request vector and `ptr`. Outputs: one-hot winner, winner index, any-valid.
- The FSM, timeout counter, lock logic and data register stay in `uart_tx_arbiter`.

## Test plan
- **Single requester:** `req_valid[0]`=1, data 8'hA5, tx model ACKs in 2 cycles → `tx_din`=8'hA5, one `req_ready[0]` pulse, `tx_din_rdy` high from cycle 3 until the ACK.
- **All four valid continuously:** grants in order 0,1,2,3,0 with bytes 8'h10,8'h21,8'h32,8'h43; each byte is loaded once.
- **Stuck tx model** (`tx_rdy` stays 1): `err_timeout` pulses exactly 64 cycles after LOAD, then FSM returns to IDLE and the next requester is served.
- **Reset asserted in WAIT_DONE:** next cycle all outputs are at reset values; after release, requester 0 is granted first.
- **`UART_TX_ARB_LOCK_EN`:** requester 2 sends 3 bytes with `req_last`=0,0,1 while requester 1 is valid → bytes 2,2,2 sent, then requester 1.
- **Back-to-back bytes:** `tx_din_rdy` is low for ≥2 cycles between loads, and the tx model sees a rising edge for every byte.
